// File: rtl/emg_pkg.sv
// Shared definitions for the multi-window EMG detector: FSM encoding,
// default tuning values and the signed/unsigned magnitude helper.
package emg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_DECIDE = 2'd2
    } emg_state_e;

    localparam int WIN_DEF    = 50;
    localparam int AMP_TH_DEF = 75;
    localparam int ON_TH_DEF  = 3;
    localparam int OFF_TH_DEF = 2;

    // Magnitude of the low dw bits of sample; the most negative code maps to 2^(dw-1).
    function automatic logic [63:0] magnitude(input logic [63:0] sample,
                                              input int          dw,
                                              input bit          signed_in);
        logic [63:0] mask;
        logic [63:0] raw;
        mask = (64'd1 << dw) - 64'd1;
        raw  = sample & mask;
        if (signed_in && raw[dw-1])
            return (~raw + 64'd1) & mask;
        else
            return raw;
    endfunction

endpackage

// File: rtl/emg_multi_window_detector_if.sv
// Sample/decision bus between the ADC front end and the detector.
interface emg_multi_window_detector_if
    import emg_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int DW   = 8,
    parameter int WIN  = WIN_DEF
);
    localparam int CW = $clog2(WIN + 1);

    logic                 en;
    logic                 sample_tick;
    logic [N_CH*DW-1:0]   d;
    logic [N_CH-1:0]      ctrl;
    logic                 wr;
    logic [N_CH*CW-1:0]   cnt_last;

    modport master (
        output en, sample_tick, d,
        input  ctrl, wr, cnt_last
    );

    modport slave (
        input  en, sample_tick, d,
        output ctrl, wr, cnt_last
    );

endinterface

// File: rtl/emg_ch_counter.sv
// One channel: threshold compare, saturating window count and hysteresis
// control bit. Sequencing comes from the shared FSM in the top level.
module emg_ch_counter
    import emg_pkg::*;
#(
    parameter int DW        = 8,
    parameter int WIN       = WIN_DEF,
    parameter int AMP_TH    = AMP_TH_DEF,
    parameter int ON_TH     = ON_TH_DEF,
    parameter int OFF_TH    = OFF_TH_DEF,
    parameter int SIGNED_IN = 0,
    localparam int CW       = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] sample,
    input  logic          clear,
    input  logic          acc_take,
    input  logic          last,
    input  logic          restart,
    input  logic          load_take,
    output logic          ctrl,
    output logic [CW-1:0] cnt_last
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] c_next;
    logic          above;
    logic          inc;

    assign above  = magnitude(64'(sample), DW, SIGNED_IN != 0) > 64'(AMP_TH);
    assign inc    = acc_take && above && (cnt != CW'(WIN));
    assign c_next = cnt + CW'(inc);

    // The decision uses the count including the WIN-th sample, so ctrl and
    // cnt_last land on the same edge that raises wr in the top level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            ctrl     <= 1'b0;
            cnt_last <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (last) begin
            cnt      <= '0;
            cnt_last <= c_next;
            if (c_next >= CW'(ON_TH))
                ctrl <= 1'b1;
            else if (c_next < CW'(OFF_TH))
                ctrl <= 1'b0;
        end else if (restart) begin
            cnt <= (load_take && above) ? CW'(1) : '0;
        end else if (acc_take) begin
            cnt <= c_next;
        end
    end

endmodule

// File: rtl/emg_multi_window_detector.sv
// Multi-channel EMG window detector: shared window FSM and sample index,
// with one emg_ch_counter per channel.
module emg_multi_window_detector
    import emg_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DW        = 8,
    parameter int WIN       = WIN_DEF,
    parameter int AMP_TH    = AMP_TH_DEF,
    parameter int ON_TH     = ON_TH_DEF,
    parameter int OFF_TH    = OFF_TH_DEF,
    parameter int SIGNED_IN = 0,
    localparam int CW       = $clog2(WIN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    emg_multi_window_detector_if.slave    bus
);

    emg_state_e    state;
    logic [CW-1:0] n;
    logic          wr_q;

    logic clear;
    logic acc_take;
    logic last;
    logic restart;
    logic load_take;

    assign clear     = (state == ST_IDLE) || ((state == ST_ACC) && !bus.en);
    assign acc_take  = (state == ST_ACC) && bus.en && bus.sample_tick;
    assign last      = acc_take && (n == CW'(WIN - 1));
    assign restart   = (state == ST_DECIDE);
    assign load_take = restart && bus.en && bus.sample_tick;

    // DECIDE is the single cycle in which wr is high; a tick landing there
    // is already sample 1 of the following window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            n     <= '0;
            wr_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    n <= '0;
                    if (bus.en)
                        state <= ST_ACC;
                end
                ST_ACC: begin
                    if (!bus.en) begin
                        state <= ST_IDLE;
                        n     <= '0;
                    end else if (bus.sample_tick) begin
                        if (n == CW'(WIN - 1)) begin
                            state <= ST_DECIDE;
                            n     <= '0;
                            wr_q  <= 1'b1;
                        end else begin
                            n <= n + CW'(1);
                        end
                    end
                end
                ST_DECIDE: begin
                    if (bus.en) begin
                        state <= ST_ACC;
                        n     <= bus.sample_tick ? CW'(1) : '0;
                    end else begin
                        state <= ST_IDLE;
                        n     <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    n     <= '0;
                end
            endcase
        end
    end

    assign bus.wr = wr_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        emg_ch_counter #(
            .DW        (DW),
            .WIN       (WIN),
            .AMP_TH    (AMP_TH),
            .ON_TH     (ON_TH),
            .OFF_TH    (OFF_TH),
            .SIGNED_IN (SIGNED_IN)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sample    (bus.d[i*DW +: DW]),
            .clear     (clear),
            .acc_take  (acc_take),
            .last      (last),
            .restart   (restart),
            .load_take (load_take),
            .ctrl      (bus.ctrl[i]),
            .cnt_last  (bus.cnt_last[i*CW +: CW])
        );
    end

endmodule

// File: tb/tb_emg_multi_window_detector.sv
// Directed bench: an unsigned and a signed detector (WIN=8, AMP_TH=75,
// ON=3, OFF=2) driven with the same hand-computed windows.
module tb_emg_multi_window_detector;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    emg_multi_window_detector_if #(.N_CH(2), .DW(8), .WIN(8)) bus_u ();
    emg_multi_window_detector_if #(.N_CH(2), .DW(8), .WIN(8)) bus_s ();

    emg_multi_window_detector #(
        .N_CH(2), .DW(8), .WIN(8), .AMP_TH(75), .ON_TH(3), .OFF_TH(2), .SIGNED_IN(0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u.slave)
    );

    emg_multi_window_detector #(
        .N_CH(2), .DW(8), .WIN(8), .AMP_TH(75), .ON_TH(3), .OFF_TH(2), .SIGNED_IN(1)
    ) s_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, return just after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic tick,
                                 input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        reset             = rst;
        bus_u.en          = en;
        bus_u.sample_tick = tick;
        bus_u.d           = {d1, d0};
        bus_s.en          = en;
        bus_s.sample_tick = tick;
        bus_s.d           = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    task automatic checkWr(input string tag, input logic exp_wr);
        checks++;
        assert (bus_u.wr === exp_wr) else begin
            errors++;
            $error("[TB] FAIL %s wr: observed %b expected %b", tag, bus_u.wr, exp_wr);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_wr, input logic [1:0] exp_ctrl,
                               input logic [3:0] exp_c0, input logic [3:0] exp_c1);
        checkWr(tag, exp_wr);
        checks++;
        assert (bus_u.ctrl === exp_ctrl) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, bus_u.ctrl, exp_ctrl);
        end
        checks++;
        assert (bus_u.cnt_last[3:0] === exp_c0) else begin
            errors++;
            $error("[TB] FAIL %s cnt_last0: observed %0d expected %0d", tag, bus_u.cnt_last[3:0], exp_c0);
        end
        checks++;
        assert (bus_u.cnt_last[7:4] === exp_c1) else begin
            errors++;
            $error("[TB] FAIL %s cnt_last1: observed %0d expected %0d", tag, bus_u.cnt_last[7:4], exp_c1);
        end
    endtask

    task automatic checkSignedOutput(input string tag, input logic exp_wr,
                                     input logic [1:0] exp_ctrl, input logic [3:0] exp_c0);
        checks++;
        assert (bus_s.wr === exp_wr) else begin
            errors++;
            $error("[TB] FAIL %s signed wr: observed %b expected %b", tag, bus_s.wr, exp_wr);
        end
        checks++;
        assert (bus_s.ctrl === exp_ctrl) else begin
            errors++;
            $error("[TB] FAIL %s signed ctrl: observed %b expected %b", tag, bus_s.ctrl, exp_ctrl);
        end
        checks++;
        assert (bus_s.cnt_last[3:0] === exp_c0) else begin
            errors++;
            $error("[TB] FAIL %s signed cnt_last0: observed %0d expected %0d", tag, bus_s.cnt_last[3:0], exp_c0);
        end
    endtask

    // Eight back-to-back ticks; wr must stay low until the cycle after the eighth.
    task automatic runWindow(input string tag, input logic [7:0] s0 [8], input logic [7:0] s1 [8],
                             input logic [1:0] exp_ctrl, input logic [3:0] exp_c0, input logic [3:0] exp_c1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, s0[i], s1[i]);
            if (i < 7)
                checkWr(tag, 1'b0);
        end
        checkOutput(tag, 1'b1, exp_ctrl, exp_c0, exp_c1);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        bus_u.en          = 1'b0;
        bus_u.sample_tick = 1'b0;
        bus_u.d           = '0;
        bus_s.en          = 1'b0;
        bus_s.sample_tick = 1'b0;
        bus_s.d           = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("reset", 1'b0, 2'b00, 4'd0, 4'd0);
        checkSignedOutput("reset", 1'b0, 2'b00, 4'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        // Tick seen in IDLE while enabling must be ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 8'd200);
        checkOutput("idle_tick", 1'b0, 2'b00, 4'd0, 4'd0);

        runWindow("w1_basic", '{8'd80, 8'd90, 8'd100, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10},
                  '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 2'b01, 4'd3, 4'd0);
        checkSignedOutput("w1_basic", 1'b1, 2'b01, 4'd3);

        // First tick lands in DECIDE; 75 is exactly at threshold and must not count.
        runWindow("w2_hold", '{8'd200, 8'd75, 8'd76, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  '{8'd76, 8'd76, 8'd76, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b11, 4'd2, 4'd3);
        checkSignedOutput("w2_hold", 1'b1, 2'b10, 4'd1);

        runWindow("w3_clear", '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b00, 4'd1, 4'd0);

        // -128, -76, -75, +75: signed counts 2, unsigned reads 128,180,181 -> 3.
        runWindow("w4_signed", '{8'h80, 8'hB4, 8'hB5, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00},
                  '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b01, 4'd3, 4'd0);
        checkSignedOutput("w4_signed", 1'b1, 2'b00, 4'd2);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 8'd200);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("en_drop", 1'b0, 2'b01, 4'd3, 4'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'd200, 8'd200);
        checkOutput("en_low_ticks", 1'b0, 2'b01, 4'd3, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        checkOutput("re_enable", 1'b0, 2'b01, 4'd3, 4'd0);

        // Partial counts from the aborted window must be gone; ch1 saturates at WIN.
        runWindow("w6_fresh", '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd80},
                  '{8'd76, 8'd76, 8'd76, 8'd76, 8'd76, 8'd76, 8'd76, 8'd76}, 2'b10, 4'd1, 4'd8);
        checkSignedOutput("w6_fresh", 1'b1, 2'b10, 4'd1);

        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 8'd200);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd200, 8'd200);
        checkOutput("mid_reset", 1'b0, 2'b00, 4'd0, 4'd0);
        checkSignedOutput("mid_reset", 1'b0, 2'b00, 4'd0);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 8'd200);
        checkWr("post_reset_idle", 1'b0);
        runWindow("w8_after_reset", '{8'd76, 8'd76, 8'd76, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b01, 4'd3, 4'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("final_idle", 1'b0, 2'b01, 4'd3, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/emg_multi_window_detector.md
Name: emg_multi_window_detector

Overview:
- Multi-channel, parametrised successor to the single-channel EMG threshold detector.
- Counts, per channel, how many samples in a fixed window of WIN sample ticks exceed an amplitude threshold. At each window end it updates one control bit per channel using on/off hysteresis and pulses a write strobe.
- Sits between the ADC sampling front end and the actuator/motor command logic.
- Runs back-to-back windows with no lost samples, optionally on signed (two's-complement) input.

Parameters:
- N_CH, 2, number of EMG channels.
- DW, 8, sample width per channel.
- WIN, 50, samples per window; legal range 2..1023.
- AMP_TH, 75, amplitude threshold; unsigned, DW bits; a sample counts when its magnitude is strictly greater than AMP_TH.
- ON_TH, 3, window count at or above which a channel's ctrl is set.
- OFF_TH, 2, window count below which a channel's ctrl is cleared; must satisfy 1 <= OFF_TH <= ON_TH <= WIN.
- SIGNED_IN, 0, 1 means each sample is two's complement and its magnitude |d| (DW bits unsigned, so |-2^(DW-1)| = 2^(DW-1)) is compared.
- CW, $clog2(WIN+1), derived count width; not to be overridden.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- en, input, 1, level enable; windows run only while en=1.
- sample_tick, input, 1, one-cycle strobe; d is valid in the same cycle.
- d, input, N_CH*DW, packed samples; channel i occupies bits [i*DW +: DW].
- ctrl, output, N_CH, registered per-channel control decision.
- wr, output, 1, one-cycle pulse when ctrl and cnt_last are updated.
- cnt_last, output, N_CH*CW, per-channel above-threshold count of the last completed window.

Behaviour:
- Reset: state=IDLE; all counters 0; ctrl=0; wr=0; cnt_last=0.
- States: IDLE, ACC, DECIDE.
- IDLE: counters held at 0. When en=1, go to ACC the next cycle. Ticks seen in IDLE are ignored.
- ACC, on each tick:
  - Sample index n increments.
  - Each channel's count increments if its sample is above threshold; the count saturates at WIN and cannot overflow.
  - On the tick where n reaches WIN (the WIN-th sample is included in the count), go to DECIDE.
- DECIDE (exactly one cycle), per channel, using the final count c:
  - c >= ON_TH: ctrl <= 1.
  - c < OFF_TH: ctrl <= 0.
  - Otherwise ctrl holds.
  - cnt_last <= c.
  - wr=1 for this one cycle.
- Leaving DECIDE: if en=1, go to ACC with the next window started; otherwise go to IDLE.
- Tick in the DECIDE cycle: becomes sample 1 of the next window (n=1, counts load that sample's contribution), so no sample is dropped. If en=0, the tick is discarded.
- Latency: wr asserts one clk cycle after the WIN-th tick. ctrl and cnt_last change in the same cycle that wr is high.
- Registered outputs: wr, ctrl and cnt_last come straight from flops with no combinational path from inputs.
- en dropped mid-window (ACC): go to IDLE next cycle; partial counts discarded; no wr; ctrl holds its value. Re-enabling starts a fresh window.
- sample_tick held high for several cycles: each high cycle is one sample. No minimum spacing between ticks.
- reset asserted mid-window or mid-DECIDE: immediate return to reset values; any pending wr is suppressed.
- Channels are fully independent apart from the shared sample index and shared wr.

Decomposition:
- Shared package emg_pkg holds:
  - state encoding constants (IDLE, ACC, DECIDE);
  - the default values of WIN, AMP_TH, ON_TH and OFF_TH;
  - a function for magnitude extraction with signed/unsigned select.
- Sub-module emg_ch_counter, instantiated N_CH times via generate. Each instance contains:
  - the magnitude compare;
  - the saturating count register with clear/load-first-sample control;
  - the hysteresis ctrl flop.
- Top level holds the FSM and the sample index counter.

Test Plan:
- N_CH=2, WIN=8, AMP_TH=75, ON=3, OFF=2. Window 1 gives ch0 samples {80,90,100,10,10,10,10,10} and ch1 all 50 -> wr pulses 1 cycle after the 8th tick; ctrl=2'b01; cnt_last ch0=3, ch1=0.
- Hysteresis, same parameters: ch0 window counts 3, then 2, then 1 -> ctrl[0] sequence 1, 1 (held), 0. Boundary case: ch0 sample exactly 75 -> not counted.
- Tick asserted in the DECIDE cycle with ch0=200 -> next window's cnt_last ch0 includes it (sample of 200 in slot 1, all others 0 -> cnt_last=1). Exactly 8 ticks separate consecutive wr pulses.
- SIGNED_IN=1: ch0 samples -128 and -76 count, -75 and +75 do not. 8 samples {-128,-76,-75,75,0,0,0,0} -> cnt_last=2.
- en dropped after 5 ticks, then raised again with 8 more ticks -> no wr until 8 ticks after re-enable; ctrl holds its earlier value in between.
- reset pulsed on the 7th tick of a window -> ctrl=0, wr=0, cnt_last=0. The next wr appears only after a full 8 ticks once en is seen in IDLE.
